tdc_event_arbiter: RTL

Parametrised N-channel successor to the two-TDC output controller. It collects hit words from NUM_CHANNELS TDC channels and arbitrates among pending channels, round-robin or fixed-priority. It writes one tagged word per cycle into the acquisition FIFO and clears the served channel. It also keeps saturating per-channel accepted-event counters for the event-rate readout.

---
 rtl/tdc_event_arbiter_if.sv | 34 +++
 rtl/tdc_event_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/tdc_event_arbiter_if.sv
// TDC event arbiter bus: channel hit side plus acquisition FIFO write side.
// master = TDC/FIFO environment, slave = arbiter.
interface tdc_event_arbiter_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int PAYLOAD_W    = 64
) ();
  localparam int ID_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DATA_W = ID_W + PAYLOAD_W;

  logic [NUM_CHANNELS-1:0]                ev_valid;
  logic [NUM_CHANNELS-1:0][PAYLOAD_W-1:0] ev_payload;
  logic [NUM_CHANNELS-1:0]                ev_clear;
  logic                                   fifo_full;
  logic [DATA_W-1:0]                      o_data;
  logic                                   o_write;

  modport master (
    output ev_valid,
    output ev_payload,
    output fifo_full,
    input  ev_clear,
    input  o_data,
    input  o_write
  );

  modport slave (
    input  ev_valid,
    input  ev_payload,
    input  fifo_full,
    output ev_clear,
    output o_data,
    output o_write
  );
endinterface

// File: rtl/tdc_event_arbiter.sv
// N-channel TDC hit arbiter: one tagged word per cycle into the FIFO,
// round-robin or fixed priority, with saturating per-channel counters.
module tdc_event_arbiter #(
  parameter int NUM_CHANNELS = 8,
  parameter int PAYLOAD_W    = 64,
  parameter int ARB_MODE     = 1,
  parameter int COUNT_W      = 16,
  localparam int ID_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int DATA_W = ID_W + PAYLOAD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  tdc_event_arbiter_if.slave      bus,
  output logic [NUM_CHANNELS-1:0] sel_onehot,
  input  logic                    cnt_clear,
  input  logic [ID_W-1:0]         cnt_sel,
  output logic [COUNT_W-1:0]      cnt_data
);

  logic [NUM_CHANNELS-1:0] clr_q, clr_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [DATA_W-1:0]       o_data_q, o_data_d;
  logic                    o_write_q, o_write_d;
  logic [COUNT_W-1:0]      cnt_q [NUM_CHANNELS];
  logic [COUNT_W-1:0]      cnt_d [NUM_CHANNELS];
  logic [COUNT_W-1:0]      cnt_data_q, cnt_data_d;

  logic [NUM_CHANNELS-1:0] elig;
  logic                    gnt_vld;
  logic [ID_W-1:0]         gnt_idx;
  logic [ID_W:0]           sum;

  // Channels cleared last cycle still show a stale ev_valid; mask them.
  always_comb begin
    elig    = bus.ev_valid & ~clr_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    if (!bus.fifo_full) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_CHANNELS))
          sum = sum - (ID_W+1)'(NUM_CHANNELS);
        if (!gnt_vld && elig[sum[ID_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = sum[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    o_data_d  = o_data_q;
    o_write_d = gnt_vld;
    clr_d     = '0;
    if (gnt_vld) begin
      o_data_d = {gnt_idx, bus.ev_payload[gnt_idx]};
      clr_d    = NUM_CHANNELS'(1) << gnt_idx;
      if (ARB_MODE == 0)
        ptr_d = '0;
      else if (gnt_idx == ID_W'(NUM_CHANNELS - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + 1'b1;
    end
  end

  // cnt_clear wins over the same-cycle increment.
  always_comb begin
    cnt_data_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clear)
        cnt_d[i] = '0;
      else if (gnt_vld && gnt_idx == ID_W'(i) && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 1'b1;
      if (cnt_sel == ID_W'(i))
        cnt_data_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_q      <= '0;
      ptr_q      <= '0;
      o_data_q   <= '0;
      o_write_q  <= 1'b0;
      cnt_data_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
        cnt_q[i] <= '0;
    end else begin
      clr_q      <= clr_d;
      ptr_q      <= ptr_d;
      o_data_q   <= o_data_d;
      o_write_q  <= o_write_d;
      cnt_data_q <= cnt_data_d;
      for (int i = 0; i < NUM_CHANNELS; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  // Reset flushes every TDC through a full clear.
  assign bus.ev_clear = reset ? '1 : clr_q;
  assign sel_onehot   = reset ? '0 : clr_q;
  assign bus.o_data   = o_data_q;
  assign bus.o_write  = o_write_q;
  assign cnt_data     = cnt_data_q;

endmodule
